// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life engine.
// Holds the FSM state encoding, default grid size and counter helpers.
package life_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Saturating increment used for the generation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/life_cell.sv
// Single Game-of-Life cell: eight neighbour bits plus the current bit
// produce the cell's next-generation value (purely combinational).
module life_cell
    import life_pkg::*;
(
    input  logic [7:0] nbrs,
    input  logic       cur,
    output logic       nxt
);

    logic [3:0] cnt_s;

    // Neighbour population count followed by the survive/birth rule.
    always_comb begin
        cnt_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_s = cnt_s + {3'd0, nbrs[i]};
        end
        if (cnt_s == 4'd3) begin
            nxt = 1'b1;
        end else if (cnt_s == 4'd2) begin
            nxt = cur;
        end else begin
            nxt = 1'b0;
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: a ROWS x COLS grid advanced one generation per
// tick (free-run) or per step pulse (paused), with stable/extinct flags.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int WRAP           = 1,
    parameter int STOP_ON_STABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 load,
    input  logic                 power,
    input  logic                 step,
    input  logic [CNT_W-1:0]     period,
    output logic [ROWS*COLS-1:0] grid,
    output logic [CNT_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int N = ROWS * COLS;

    state_t           state_r;
    logic [N-1:0]     grid_r;
    logic [N-1:0]     next_s;
    logic [CNT_W-1:0] gen_count_r;
    logic [CNT_W-1:0] tick_r;
    logic             stable_r;
    logic             extinct_r;

    logic             tick_hit_s;
    logic             same_s;
    logic             next_empty_s;
    logic             gen_fire_s;

    // Neighbour wiring: k enumerates the 8 offsets row-major, skipping centre.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = (ROWS - 1 - r) * COLS + (COLS - 1 - c);
            logic [7:0] nbr_s;

            for (genvar k = 0; k < 8; k++) begin : g_nbr
                localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                                    ((k == 1 || k == 6) ? 0 : 1);
                localparam int RR = r + DR;
                localparam int CC = c + DC;

                if (WRAP != 0 || (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS)) begin : g_in
                    assign nbr_s[k] = grid_r[(ROWS - 1 - ((RR + ROWS) % ROWS)) * COLS
                                           + (COLS - 1 - ((CC + COLS) % COLS))];
                end else begin : g_out
                    assign nbr_s[k] = 1'b0;
                end
            end

            life_cell u_cell (
                .nbrs (nbr_s),
                .cur  (grid_r[IDX]),
                .nxt  (next_s[IDX])
            );
        end
    end

    // Decide whether this cycle commits a new generation; load always wins.
    always_comb begin
        tick_hit_s   = (tick_r == period);
        same_s       = (next_s == grid_r);
        next_empty_s = ~|next_s;
        gen_fire_s   = 1'b0;
        if (load) begin
            gen_fire_s = 1'b0;
        end else begin
            case (state_r)
                ST_PAUSE: gen_fire_s = ~power & step;
                ST_RUN:   gen_fire_s = power & tick_hit_s;
                default:  gen_fire_s = 1'b0;
            endcase
        end
    end

    // Control FSM together with all registered grid state and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            grid_r      <= {N{1'b0}};
            gen_count_r <= CNT_ZERO;
            tick_r      <= CNT_ZERO;
            stable_r    <= 1'b0;
            extinct_r   <= 1'b1;
        end else if (load) begin
            state_r     <= ST_PAUSE;
            grid_r      <= seed;
            gen_count_r <= CNT_ZERO;
            tick_r      <= CNT_ZERO;
            stable_r    <= 1'b0;
            extinct_r   <= ~|seed;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_PAUSE: begin
                    if (power) begin
                        state_r <= ST_RUN;
                        tick_r  <= CNT_ZERO;
                    end else begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_RUN: begin
                    if (!power) begin
                        state_r <= ST_PAUSE;
                        tick_r  <= CNT_ZERO;
                    end else if (tick_hit_s) begin
                        tick_r  <= CNT_ZERO;
                    end else begin
                        tick_r  <= tick_r + CNT_ONE;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // A stable generation still counts; halting overrides the case above.
            if (gen_fire_s) begin
                grid_r      <= next_s;
                gen_count_r <= sat_inc(gen_count_r);
                stable_r    <= same_s;
                extinct_r   <= next_empty_s;
                if (same_s && STOP_ON_STABLE != 0) begin
                    state_r <= ST_HALT;
                end else begin
                    state_r <= state_r;
                end
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    assign grid      = grid_r;
    assign gen_count = gen_count_r;
    assign stable    = stable_r;
    assign extinct   = extinct_r;

endmodule

// File: tb/tb_life_engine.sv
// Directed self-checking bench for life_engine on 8x8 grids,
// one instance with dead edges and one toroidal.
module tb_life_engine;
    import life_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] seed;
    logic        load;
    logic        power;
    logic        step;
    logic [15:0] period;

    logic [63:0] grid0, grid1;
    logic [15:0] gc0, gc1;
    logic        st0, st1, ex0, ex1;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] P_LINE4  = 64'h0000_00F0_0000_0000;
    localparam logic [63:0] P_LINE4N = 64'h0000_6060_6000_0000;
    localparam logic [63:0] P_TOP3   = 64'hE000_0000_0000_0000;
    localparam logic [63:0] P_TOP3_D = 64'h4040_0000_0000_0000;
    localparam logic [63:0] P_TOP3_W = 64'h4040_0000_0000_0040;
    localparam logic [63:0] P_BLINKH = 64'h0000_0038_0000_0000;
    localparam logic [63:0] P_BLINKV = 64'h0000_1010_1000_0000;
    localparam logic [63:0] P_BLOCK  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] P_GLIDER = 64'h4020_E000_0000_0000;
    localparam logic [63:0] P_ZERO   = 64'h0000_0000_0000_0000;

    always #5 clk = ~clk;

    life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .STOP_ON_STABLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .seed(seed), .load(load), .power(power),
        .step(step), .period(period), .grid(grid0), .gen_count(gc0),
        .stable(st0), .extinct(ex0)
    );

    life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .STOP_ON_STABLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .seed(seed), .load(load), .power(power),
        .step(step), .period(period), .grid(grid1), .gen_count(gc1),
        .stable(st1), .extinct(ex1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] s);
        seed = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; seed = P_BLOCK; load = 1'b0; power = 1'b0; step = 1'b0; period = 16'd0;
        cyc(); cyc();
        tests++;
        if (grid0 !== P_ZERO || gc0 !== 16'd0 || st0 !== 1'b0 || ex0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_vals: grid=%h gc=%0d st=%b ex=%b want 0/0/0/1", grid0, gc0, st0, ex0);
        end
        reset = 1'b1;
        cyc();
        power = 1'b1; step = 1'b1;
        cyc(); cyc();
        tests++;
        if (u_dut0.state_r !== ST_IDLE || grid0 !== P_ZERO || gc0 !== 16'd0) begin
            fails++;
            $display("FAIL idle_ignore: state=%0d grid=%h gc=%0d want IDLE/0/0", u_dut0.state_r, grid0, gc0);
        end
        power = 1'b0; step = 1'b0;
    endtask

    task automatic test_step();
        do_load(P_LINE4);
        tests++;
        if (grid0 !== P_LINE4 || gc0 !== 16'd0 || u_dut0.state_r !== ST_PAUSE || ex0 !== 1'b0) begin
            fails++;
            $display("FAIL load: grid=%h gc=%0d state=%0d ex=%b want %h/0/PAUSE/0", grid0, gc0, u_dut0.state_r, ex0, P_LINE4);
        end
        step = 1'b1; cyc(); step = 1'b0;
        tests++;
        if (grid0 !== P_LINE4N || gc0 !== 16'd1 || st0 !== 1'b0) begin
            fails++;
            $display("FAIL step_line4: grid=%h gc=%0d st=%b want %h/1/0", grid0, gc0, st0, P_LINE4N);
        end
        cyc();
        tests++;
        if (grid0 !== P_LINE4N || gc0 !== 16'd1) begin
            fails++;
            $display("FAIL pause_hold: grid=%h gc=%0d want %h/1", grid0, gc0, P_LINE4N);
        end
        do_load(P_TOP3);
        step = 1'b1; cyc(); step = 1'b0;
        tests++;
        if (grid0 !== P_TOP3_D) begin
            fails++;
            $display("FAIL edge_dead: grid=%h want %h", grid0, P_TOP3_D);
        end
        tests++;
        if (grid1 !== P_TOP3_W) begin
            fails++;
            $display("FAIL edge_wrap: grid=%h want %h", grid1, P_TOP3_W);
        end
    endtask

    task automatic test_blinker();
        logic [63:0] exp_g;
        do_load(P_BLINKH);
        period = 16'd0; power = 1'b1;
        cyc();
        tests++;
        if (grid0 !== P_BLINKH || gc0 !== 16'd0 || u_dut0.state_r !== ST_RUN) begin
            fails++;
            $display("FAIL run_enter: grid=%h gc=%0d state=%0d want %h/0/RUN", grid0, gc0, u_dut0.state_r, P_BLINKH);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            exp_g = (i % 2 == 1) ? P_BLINKV : P_BLINKH;
            tests++;
            if (grid0 !== exp_g || st0 !== 1'b0 || gc0 !== 16'(i)) begin
                fails++;
                $display("FAIL blinker_%0d: grid=%h st=%b gc=%0d want %h/0/%0d", i, grid0, st0, gc0, exp_g, i);
            end
        end
        power = 1'b0;
        cyc();
        tests++;
        if (grid0 !== P_BLINKH || gc0 !== 16'd6 || u_dut0.state_r !== ST_PAUSE) begin
            fails++;
            $display("FAIL run_to_pause: grid=%h gc=%0d state=%0d want %h/6/PAUSE", grid0, gc0, u_dut0.state_r, P_BLINKH);
        end
    endtask

    task automatic test_block();
        int bad;
        do_load(P_BLOCK);
        period = 16'd0; power = 1'b1;
        cyc(); cyc();
        tests++;
        if (st0 !== 1'b1 || gc0 !== 16'd1 || u_dut0.state_r !== ST_HALT || grid0 !== P_BLOCK) begin
            fails++;
            $display("FAIL block_halt: st=%b gc=%0d state=%0d grid=%h want 1/1/HALT/%h", st0, gc0, u_dut0.state_r, grid0, P_BLOCK);
        end
        step = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (grid0 !== P_BLOCK || gc0 !== 16'd1 || u_dut0.state_r !== ST_HALT) bad++;
        end
        step = 1'b0; power = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_frozen: grid=%h gc=%0d bad_cycles=%0d want %h/1/0", grid0, gc0, bad, P_BLOCK);
        end
    endtask

    task automatic test_extinct();
        do_load(P_ZERO);
        step = 1'b1; cyc(); step = 1'b0;
        tests++;
        if (gc0 !== 16'd1 || st0 !== 1'b1 || ex0 !== 1'b1 || u_dut0.state_r !== ST_HALT) begin
            fails++;
            $display("FAIL empty_grid: gc=%0d st=%b ex=%b state=%0d want 1/1/1/HALT", gc0, st0, ex0, u_dut0.state_r);
        end
    endtask

    task automatic test_glider();
        int bad;
        do_load(P_GLIDER);
        period = 16'd3; power = 1'b1;
        cyc();
        for (int g = 1; g <= 32; g++) begin
            bad = 0;
            for (int j = 0; j < 3; j++) begin
                cyc();
                if (gc1 !== 16'(g - 1)) bad++;
            end
            cyc();
            if (gc1 !== 16'(g)) bad++;
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL glider_timing_%0d: gc=%0d bad=%0d want %0d", g, gc1, bad, g);
            end
        end
        tests++;
        if (grid1 !== P_GLIDER || st1 !== 1'b0) begin
            fails++;
            $display("FAIL glider_return: grid=%h st=%b want %h/0", grid1, st1, P_GLIDER);
        end
        power = 1'b0;
        cyc();
    endtask

    task automatic test_reset_run();
        do_load(P_BLINKH);
        period = 16'd0; power = 1'b1;
        cyc();
        repeat (5) cyc();
        tests++;
        if (gc0 !== 16'd5) begin
            fails++;
            $display("FAIL pre_reset_gc: gc=%0d want 5", gc0);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (grid0 !== P_ZERO || gc0 !== 16'd0 || st0 !== 1'b0 || ex0 !== 1'b1 || u_dut0.state_r !== ST_IDLE) begin
            fails++;
            $display("FAIL async_reset: grid=%h gc=%0d st=%b ex=%b state=%0d want 0/0/0/1/IDLE", grid0, gc0, st0, ex0, u_dut0.state_r);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(); cyc(); cyc();
        tests++;
        if (u_dut0.state_r !== ST_IDLE || grid0 !== P_ZERO || gc0 !== 16'd0) begin
            fails++;
            $display("FAIL post_reset_idle: state=%0d grid=%h gc=%0d want IDLE/0/0", u_dut0.state_r, grid0, gc0);
        end
        power = 1'b0;
    endtask

    task automatic test_load_priority();
        do_load(P_BLINKH);
        period = 16'd0; power = 1'b1;
        cyc(); cyc();
        tests++;
        if (grid0 !== P_BLINKV || gc0 !== 16'd1) begin
            fails++;
            $display("FAIL prio_setup: grid=%h gc=%0d want %h/1", grid0, gc0, P_BLINKV);
        end
        seed = P_BLOCK; load = 1'b1;
        cyc();
        load = 1'b0; power = 1'b0;
        tests++;
        if (grid0 !== P_BLOCK || gc0 !== 16'd0 || st0 !== 1'b0 || u_dut0.state_r !== ST_PAUSE) begin
            fails++;
            $display("FAIL load_over_tick: grid=%h gc=%0d st=%b state=%0d want %h/0/0/PAUSE", grid0, gc0, st0, u_dut0.state_r, P_BLOCK);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_step();
        test_blinker();
        test_block();
        test_extinct();
        test_glider();
        test_reset_run();
        test_load_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/life_engine.md
LIFE_ENGINE -- requirements
Module: life_engine

Interface
REQ-001 Parameter ROWS, default 8, grid height in cells (range 3..64).
REQ-002 Parameter COLS, default 8, grid width in cells (range 3..64).
REQ-003 Parameter WRAP, default 1: 1 = toroidal edges, 0 = cells outside the grid are dead.
REQ-004 Parameter STOP_ON_STABLE, default 1: 1 = halt when a generation equals its predecessor.
REQ-005 clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 seed  input  ROWS*COLS  initial pattern, captured on load.
REQ-008 load  input  1  loads seed into the grid; one-cycle pulse or level.
REQ-009 power  input  1  run enable: 1 = free-run, 0 = paused.
REQ-010 step  input  1  one-cycle pulse; advances exactly one generation while paused.
REQ-011 period  input  16  clock cycles between generations, minus one, in RUN.
REQ-012 grid  output  ROWS*COLS  current generation, registered.
REQ-013 gen_count  output  16  generations computed since the last load; saturates at 16'hFFFF.
REQ-014 stable  output  1  registered; set when a computed generation equals the current grid.
REQ-015 extinct  output  1  registered; 1 when grid is all zero.

Function
REQ-016 Cell (r,c) is stored at bit (ROWS-1-r)*COLS + (COLS-1-c), so row 0 occupies the MSBs and column 0 is the MSB of each row.
REQ-017 Next state per cell: a live cell with 2 or 3 live neighbours survives; a dead cell with exactly 3 becomes live; all other cells are dead next.
REQ-018 Neighbourhood is the 8 surrounding cells; with WRAP=1, indices wrap modulo ROWS/COLS; with WRAP=0, out-of-range cells count as 0.
REQ-019 FSM states: IDLE, PAUSE, RUN, HALT.
REQ-020 IDLE: grid=0; load -> PAUSE; power, step and period are ignored.
REQ-021 load in any state: grid<=seed, gen_count<=0, stable<=0, tick counter<=0, next state PAUSE; load has priority over step, power and the tick.
REQ-022 PAUSE: power=1 -> RUN with tick counter cleared; step=1 -> one generation, stays in PAUSE.
REQ-023 RUN: tick counter increments each cycle; when it equals period, one generation is computed and the counter clears; period=0 gives one generation per cycle.
REQ-024 RUN with power=0 -> PAUSE; no generation is computed in that cycle.
REQ-025 Generation latency: grid, gen_count, stable and extinct update on the clock edge that ends the tick or step cycle (1 cycle).
REQ-026 When a generation is computed and equals the current grid: stable<=1; if STOP_ON_STABLE=1, next state is HALT, otherwise gen_count still increments.
REQ-027 HALT: grid frozen; power and step ignored; only load leaves HALT.
REQ-028 An all-zero grid is stable; extinct and stable are both 1 after the first generation of an empty grid.
REQ-029 step while in RUN or HALT is ignored.
REQ-030 gen_count increments only when the grid is actually overwritten by a computed generation.

Reset
REQ-031 reset low: state=IDLE, grid=0, gen_count=0, stable=0, extinct=1, tick counter=0, applied immediately without waiting for clk.
REQ-032 Reset deassertion takes effect on the next rising clk edge; reset asserted mid-generation discards the generation.

Structure
REQ-033 Package life_pkg holds the FSM state enum, the default ROWS/COLS constants and the 16-bit counter width constant.
REQ-034 Sub-module life_cell (combinational: 8 neighbour bits plus the current bit -> next bit) is instantiated ROWS*COLS times; neighbour wiring and WRAP handling live in life_engine.

Verification
REQ-035 8x8, WRAP=0, seed bits 39:36 = 1111 (all other bits 0), load, step -> grid bytes for rows 2..4 = 8'h60, all other rows 0, gen_count=1.
REQ-036 Blinker: row 3 = 8'h38, power=1, period=0 -> grid alternates between row 3 = 8'h38 and rows 2..4 = 8'h10 every cycle; stable stays 0.
REQ-037 Block: rows 3..4 = 8'h18, power=1 -> after one generation stable=1, state HALT, gen_count=1; 5 further cycles leave the grid unchanged.
REQ-038 Glider on 8x8 with WRAP=1, period=3 -> after 32 generations the grid equals the seed; each generation occurs exactly 4 cycles apart.
REQ-039 Reset asserted during RUN at gen_count=5 -> outputs take their reset values asynchronously; after release, the state is IDLE and power=1 has no effect until load.
REQ-040 load asserted in the same cycle as a RUN tick -> grid=seed, gen_count=0, state PAUSE; no generation is applied.
